// File: rtl/result_sram_drain_if.sv
// Result stream interface: valid/ready beat channel from the results SRAM
// drain towards the host/DMA.
//   valid   : beat valid (master -> slave)
//   ready   : beat accepted (slave -> master)
//   data    : OUT_BW-bit beat payload
//   row_end : qualifies the final beat of a row
//   last    : qualifies the final beat of the whole drain
interface result_sram_drain_if #(
  parameter int OUT_BW = 64
);
  logic              valid;
  logic              ready;
  logic [OUT_BW-1:0] data;
  logic              row_end;
  logic              last;

  modport master (output valid, output data, output row_end, output last, input ready);
  modport slave  (input valid, input data, input row_end, input last, output ready);
endinterface

// File: rtl/result_sram_drain.sv
// result_sram_drain
// Reader side of the results SRAM. Reads a programmed run of rows starting at
// base_addr and serialises each PARTIAL_SUM_BW*MATRIX_SIZE row into OUT_BW-bit
// beats, least-significant chunk (partial sum 0) first.
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   start            1-cycle pulse, accepted only while idle
//   base_addr        first row address, sampled on accepted start
//   row_count        rows to drain, sampled on accepted start (0 allowed)
//   sram_rd_en/addr  read strobe and address towards the results SRAM
//   sram_rd_data     row data, valid exactly one cycle after sram_rd_en
//   m                result stream (master modport); its OUT_BW must match
//   busy             high from accepted start until completion
//   done             1-cycle completion pulse
// Build option: DRAIN_CHECKSUM_EN appends one beat carrying the XOR of every
// data beat of the drain (flagged row_end and last).
module result_sram_drain #(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int MATRIX_SIZE    = 64,
  parameter int OUT_BW         = 64
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 start,
  input  logic [ADDRESSSIZE-1:0]               base_addr,
  input  logic [ADDRESSSIZE:0]                 row_count,
  output logic                                 sram_rd_en,
  output logic [ADDRESSSIZE-1:0]               sram_rd_addr,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_rd_data,
  result_sram_drain_if.master                  m,
  output logic                                 busy,
  output logic                                 done
);

  localparam int ROW_BW = PARTIAL_SUM_BW * MATRIX_SIZE;
  localparam int BEATS  = ROW_BW / OUT_BW;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_EMPTY, S_RD, S_WAIT, S_LOAD, S_SEND, S_CSUM, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] cur_addr;
  logic [ADDRESSSIZE:0]   rows_left;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [ROW_BW-1:0]      row_sr;
`ifdef DRAIN_CHECKSUM_EN
  logic [OUT_BW-1:0]      csum;
`endif

  logic beat_acc, last_beat, last_row;
  assign beat_acc  = (state_q == S_SEND) && m.ready;
  assign last_beat = (beat_cnt == BEAT_W'(BEATS - 1));
  assign last_row  = (rows_left == (ADDRESSSIZE+1)'(1));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. A zero-length drain still passes through one busy
  // cycle (S_EMPTY) so done lands on the same cycle offset as any other start.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (row_count == '0) ? S_EMPTY : S_RD;
      S_EMPTY: state_d = S_DONE;
      S_RD:    state_d = S_WAIT;
      S_WAIT:  state_d = S_LOAD;
      S_LOAD:  state_d = S_SEND;
      S_SEND: begin
        if (beat_acc && last_beat) begin
`ifdef DRAIN_CHECKSUM_EN
          state_d = last_row ? S_CSUM : S_RD;
`else
          state_d = last_row ? S_DONE : S_RD;
`endif
        end
      end
      S_CSUM:  if (m.ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Address, row counters and row shift register. SRAM data is only valid in
  // the cycle after the strobe (WAIT), so the row is captured on the edge
  // leaving WAIT; LOAD is the bubble before the first beat is presented.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_addr  <= '0;
      rows_left <= '0;
      beat_cnt  <= '0;
      row_sr    <= '0;
`ifdef DRAIN_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            rows_left <= row_count;
`ifdef DRAIN_CHECKSUM_EN
            csum      <= '0;
`endif
          end
        end
        S_RD: cur_addr <= cur_addr + ADDRESSSIZE'(1);  // wraps modulo 2^ADDRESSSIZE
        S_WAIT: begin
          row_sr   <= sram_rd_data;
          beat_cnt <= '0;
        end
        S_SEND: begin
          if (beat_acc) begin
            row_sr   <= row_sr >> OUT_BW;
            beat_cnt <= beat_cnt + BEAT_W'(1);
`ifdef DRAIN_CHECKSUM_EN
            csum     <= csum ^ row_sr[OUT_BW-1:0];
`endif
            if (last_beat) rows_left <= rows_left - (ADDRESSSIZE+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; beat fields come straight from registers so
  // they stay stable while a beat is stalled.
  always_comb begin
    sram_rd_en   = (state_q == S_RD);
    sram_rd_addr = cur_addr;
    busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    done         = (state_q == S_DONE);
    m.valid      = (state_q == S_SEND) || (state_q == S_CSUM);
    m.data       = row_sr[OUT_BW-1:0];
    m.row_end    = ((state_q == S_SEND) && last_beat) || (state_q == S_CSUM);
`ifdef DRAIN_CHECKSUM_EN
    if (state_q == S_CSUM) m.data = csum;
    m.last       = (state_q == S_CSUM);
`else
    m.last       = (state_q == S_SEND) && last_beat && last_row;
`endif
  end

endmodule

// File: tb/tb_result_sram_drain.sv
module tb_result_sram_drain;

  localparam int AW     = 10;
  localparam int ROW_BW = 1536;
  localparam int OUT_BW = 64;
  localparam int BEATS  = ROW_BW / OUT_BW;
`ifdef DRAIN_CHECKSUM_EN
  localparam int CSUM_BEAT = 1;
`else
  localparam int CSUM_BEAT = 0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [AW:0]       row_count;
  logic              sram_rd_en;
  logic [AW-1:0]     sram_rd_addr;
  logic [ROW_BW-1:0] sram_rd_data;
  logic              busy, done;

  result_sram_drain_if #(.OUT_BW(OUT_BW)) m_if ();

  result_sram_drain dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .row_count(row_count), .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_rd_data(sram_rd_data), .m(m_if), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: data valid only in the cycle after the strobe.
  logic [ROW_BW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
    else            sram_rd_data <= {48{32'hDEADBEEF}};
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: ready always 1; 1: ready toggles 1/0; 2: random ready
  task automatic run_drain(input int base, input int cnt, input int mode, input bit poke);
    logic [63:0] exp_q[$];
    bit          exp_re[$];
    bit          exp_la[$];
    int          addr_q[$];
    logic [ROW_BW-1:0] row;
    logic [63:0] xs, pd;
    bit          pv, pr, pre, pla;
    int          done_cyc, last_acc, first_v, rd_seen, extra, budget, a, exp_a;

    xs = '0;
    for (int r = 0; r < cnt; r++) begin
      a = (base + r) % 1024;
      addr_q.push_back(a);
      row = mem[a];
      for (int k = 0; k < BEATS; k++) begin
        exp_q.push_back(row[k*OUT_BW +: OUT_BW]);
        xs ^= row[k*OUT_BW +: OUT_BW];
        exp_re.push_back(k == BEATS-1);
        exp_la.push_back((CSUM_BEAT == 0) && (r == cnt-1) && (k == BEATS-1));
      end
    end
    if (CSUM_BEAT != 0 && cnt > 0) begin
      exp_q.push_back(xs); exp_re.push_back(1'b1); exp_la.push_back(1'b1);
    end

    @(negedge clk);
    base_addr = AW'(base); row_count = (AW+1)'(cnt); start = 1'b1; m_if.ready = 1'b1;
    done_cyc = -1; last_acc = 0; first_v = -1; rd_seen = 0; extra = 0;
    pv = 1'b0; pr = 1'b0; pd = '0; pre = 1'b0; pla = 1'b0;
    budget = cnt * 200 + 50;
    for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = poke && (cyc == 10);
      if (poke && cyc == 10) begin base_addr = AW'(base + 7); row_count = (AW+1)'(5); end
      case (mode)
        0:       m_if.ready = 1'b1;
        1:       m_if.ready = cyc[0];
        default: m_if.ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (pv && !pr) begin
        chk("stall_valid", m_if.valid, 1);
        chk("stall_data", m_if.data, pd);
        chk("stall_row_end", m_if.row_end, pre);
        chk("stall_last", m_if.last, pla);
      end
      if (sram_rd_en) begin
        rd_seen++;
        exp_a = (addr_q.size() > 0) ? addr_q.pop_front() : -1;
        chk("rd_addr", sram_rd_addr, exp_a);
      end
      if (m_if.valid && first_v < 0) first_v = cyc;
      if (m_if.valid && m_if.ready) begin
        last_acc = cyc;
        if (exp_q.size() == 0) extra++;
        else begin
          chk("beat_data", m_if.data, exp_q.pop_front());
          chk("beat_row_end", m_if.row_end, exp_re.pop_front());
          chk("beat_last", m_if.last, exp_la.pop_front());
        end
      end
      if (done) begin
        done_cyc = cyc;
        chk("done_busy", busy, 0);
        chk("done_valid", m_if.valid, 0);
      end else begin
        chk("busy", busy, 1);
      end
      pv = m_if.valid; pr = m_if.ready; pd = m_if.data; pre = m_if.row_end; pla = m_if.last;
    end
    chk("done_seen", done_cyc > 0, 1);
    chk("beats_missing", exp_q.size(), 0);
    chk("beats_extra", extra, 0);
    chk("rd_count", rd_seen, cnt);
    chk("done_cycle", done_cyc, (cnt == 0) ? 2 : last_acc + 1);
    if (mode == 0 && cnt > 0) begin
      chk("first_valid_cycle", first_v, 4);
      chk("done_cycle_full_rate", done_cyc, cnt * (BEATS + 3) + 1 + CSUM_BEAT);
    end
    // start raised during the DONE cycle must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("post_done_busy", busy, 0);
    chk("post_done_done", done, 0);
    chk("post_done_rd", sram_rd_en, 0);
    m_if.ready = 1'b0;
  endtask

  initial begin
    logic [63:0] beat0;
    rstn = 1'b0; start = 1'b0; base_addr = '0; row_count = '0; m_if.ready = 1'b0;
    for (int i = 0; i < 1024; i++)
      for (int w = 0; w < ROW_BW/32; w++) mem[i][w*32 +: 32] = $urandom;
    for (int i = 0; i < 64; i++) mem[5][i*24 +: 24] = 24'(i + 1);

    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", m_if.valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", sram_rd_en, 0);
    rstn = 1'b1;

    // Reset in the middle of SEND aborts without a done pulse
    @(negedge clk);
    base_addr = 10'd100; row_count = 11'd2; start = 1'b1; m_if.ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    chk("pre_rst_valid", m_if.valid, 1);
    rstn = 1'b0;
    #1;
    chk("midrst_valid", m_if.valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_en", sram_rd_en, 0);
    chk("midrst_data", m_if.data, 0);
    @(negedge clk);
    rstn = 1'b1;
    m_if.ready = 1'b0;

    // Known row pattern: partial sum i holds i+1
    beat0 = mem[5][63:0];
    chk("pattern_beat0", beat0, 64'h0003_0000_0200_0001);
    run_drain(5, 1, 0, 1'b0);

    // Address wrap 1022, 1023, 0
    run_drain(1022, 3, 0, 1'b0);

    // Back-pressure every other cycle, with a start poked while busy
    run_drain(300, 2, 1, 1'b1);

    // Empty drain
    run_drain(17, 0, 0, 1'b0);

    // Randomised drains with random back-pressure
    for (int t = 0; t < 4; t++)
      run_drain($urandom_range(0, 1023), $urandom_range(1, 3), 2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
